bus_source_arbiter: RTL and testbench

Round-robin arbiter that picks which of up to 25 datapath sources drives the shared 32-bit CPU bus. It turns raw drive requests into a registered one-hot grant word. That word feeds the 32-to-5 bus-select encoder directly upstream of the bus multiplexer. An all-zero grant makes the encoder emit code 31, which the bus treats as idle. The block sits between the control unit's per-source "out" strobes and the encoder.

---
 rtl/bus_source_arbiter.sv | 76 +++++++
 tb/tb_bus_source_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter: round-robin arbiter producing a registered one-hot bus grant word
//   clock       system clock, rising edge
//   clear       asynchronous active-low reset
//   req         per-source drive requests (NUM_SRC wide, level-sensitive)
//   lock        blocks preemption of the current owner while high
//   grant       registered one-hot grant, bits NUM_SRC..31 always 0
//   grant_valid registered OR of grant
//   owner       registered index of the current owner, 0 when idle
module bus_source_arbiter #(
  parameter int NUM_SRC  = 25,
  parameter int HOLD_MAX = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_SRC-1:0] req,
  input  logic               lock,
  output logic [31:0]        grant,
  output logic               grant_valid,
  output logic [4:0]         owner
);
  typedef enum logic {IDLE, OWNED} state_t;
  localparam logic [3:0] HMAX = 4'(HOLD_MAX);
  localparam logic [5:0] NS   = 6'(NUM_SRC);
  state_t      state;
  logic [4:0]  ptr, win, win_next;
  logic [3:0]  tenure;
  logic [31:0] req_x, cand;
  logic [5:0]  idx;
  logic        found, keep;
  // The owner's own bit is masked out of the search, so a release and a
  // preempt share one scan; grant is zero when idle so nothing is masked then.
  always_comb begin
    req_x = 32'(req);
    cand  = req_x & ~grant;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = 6'(ptr) + 6'(k);
      idx = idx >= NS ? idx - NS : idx;
      if (!found && cand[idx[4:0]]) begin
        found = 1'b1;
        win   = idx[4:0];
      end
    end
    win_next = win == 5'(NUM_SRC - 1) ? 5'd0 : win + 5'd1;
    // Owner keeps the bus while requesting, unless its tenure is spent,
    // someone else is waiting and lock is low.
    keep = state == OWNED && req_x[owner] && !(found && !lock && tenure >= HMAX);
  end
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      owner       <= '0;
      ptr         <= '0;
      tenure      <= '0;
    end else if (keep) begin
      tenure <= tenure >= HMAX ? tenure : tenure + 4'd1;
    end else if (found) begin
      state       <= OWNED;
      grant       <= 32'd1 << win;
      grant_valid <= 1'b1;
      owner       <= win;
      ptr         <= win_next;
      tenure      <= 4'd1;
    end else begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      owner       <= '0;
      tenure      <= '0;
    end
  end
endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb_bus_source_arbiter: scoreboard bench for bus_source_arbiter with directed vectors
module tb_bus_source_arbiter;
  logic        clock, clear, lock;
  logic [24:0] req;
  logic [31:0] grant;
  logic        grant_valid;
  logic [4:0]  owner;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] g; logic [4:0] o;} exp_t;
  exp_t q[$];

  bus_source_arbiter #(.NUM_SRC(25), .HOLD_MAX(4)) dut (
    .clock(clock), .clear(clear), .req(req), .lock(lock),
    .grant(grant), .grant_valid(grant_valid), .owner(owner)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic push(input logic [31:0] g, input logic [4:0] o);
    exp_t e;
    e.g = g;
    e.o = o;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [24:0] r, input logic l, input logic [31:0] g, input logic [4:0] o);
    @(negedge clock);
    req  = r;
    lock = l;
    push(g, o);
  endtask

  // Monitor: one expectation per edge, plus the one-hot invariant every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      chk("onehot", 32'($onehot0(grant)), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("grant", grant, e.g);
        chk("owner", 32'(owner), 32'(e.o));
        chk("valid", 32'(grant_valid), 32'(e.g != 0));
      end
    end
  end

  initial begin
    clear = 1'b0;
    req   = '1;
    lock  = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_grant", grant, 32'h0);
    chk("rst_valid", 32'(grant_valid), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    @(negedge clock);
    clear = 1'b1;
    push(32'h1, 5'd0);
    cyc(25'h0, 1'b0, 32'h0, 5'd0);
    for (int k = 0; k < 3; k++) cyc(25'd1 << 5, 1'b0, 32'h20, 5'd5);
    cyc(25'h0, 1'b0, 32'h0, 5'd0);
    @(posedge clock);
    #2;
    chk("ptr_single", 32'(dut.ptr), 32'd6);
    cyc(25'd1 << 24, 1'b0, 32'h0100_0000, 5'd24);
    cyc(25'h0, 1'b0, 32'h0, 5'd0);
    cyc((25'd1 << 2) | (25'd1 << 24), 1'b0, 32'h4, 5'd2);
    cyc(25'h0, 1'b0, 32'h0, 5'd0);
    cyc(25'd1 << 24, 1'b0, 32'h0100_0000, 5'd24);
    cyc(25'h0, 1'b0, 32'h0, 5'd0);
    for (int k = 0; k < 4; k++) cyc((25'd1 << 3) | (25'd1 << 7), 1'b0, 32'h08, 5'd3);
    for (int k = 0; k < 4; k++) cyc((25'd1 << 3) | (25'd1 << 7), 1'b0, 32'h80, 5'd7);
    for (int k = 0; k < 4; k++) cyc((25'd1 << 3) | (25'd1 << 7), 1'b0, 32'h08, 5'd3);
    cyc(25'h0, 1'b0, 32'h0, 5'd0);
    cyc(25'd1 << 1, 1'b0, 32'h2, 5'd1);
    for (int k = 0; k < 10; k++) cyc((25'd1 << 1) | (25'd1 << 9), 1'b1, 32'h2, 5'd1);
    cyc((25'd1 << 1) | (25'd1 << 9), 1'b0, 32'h200, 5'd9);
    cyc(25'd1 << 1, 1'b1, 32'h2, 5'd1);
    cyc(25'h0, 1'b0, 32'h0, 5'd0);
    cyc(25'd1 << 12, 1'b0, 32'h1000, 5'd12);
    @(posedge clock);
    #2;
    clear = 1'b0;
    #1;
    chk("async_grant", grant, 32'h0);
    chk("async_valid", 32'(grant_valid), 32'h0);
    chk("async_ptr", 32'(dut.ptr), 32'h0);
    #1;
    clear = 1'b1;
    push(32'h1000, 5'd12);
    @(posedge clock);
    #2;
    chk("ptr_after_rst", 32'(dut.ptr), 32'd13);
    cyc(25'h0, 1'b0, 32'h0, 5'd0);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clock);
    #3;
    chk("drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
